// File: rtl/ofifo_collect.sv
// ofifo_collect: per-column psum FIFOs at the south edge of the MAC array.
// Each column queues its lane independently (columns arrive skewed); a full
// row vector is presented show-ahead once every column holds data, and a
// single rd pops all lanes together.
// Optional feature: define OFIFO_RELU_EN to clamp negative lanes to zero on
// the read path (stored data stays raw).
module ofifo_collect #(
    parameter int unsigned psum_bw = 16,
    parameter int unsigned col     = 8,
    parameter int unsigned depth   = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [psum_bw*col-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [psum_bw*col-1:0] out,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready,
    output logic                   o_ovf
);

    localparam int unsigned aw    = $clog2(depth);
    localparam int unsigned ptr_w = aw + 1;

    logic [ptr_w-1:0]   wr_ptr [col];
    logic [ptr_w-1:0]   rd_ptr [col];
    logic [psum_bw-1:0] mem    [col][depth];
    logic [col-1:0]     empty;
    logic [col-1:0]     full;
    logic [col-1:0]     we;
    logic               pop;

    // Per-column empty/full from pointer compare; wrap bit separates full from empty.
    always_comb begin
        empty = '0;
        full  = '0;
        for (int c = 0; c < int'(col); c++) begin
            empty[c] = (wr_ptr[c] == rd_ptr[c]);
            full[c]  = (wr_ptr[c][aw-1:0] == rd_ptr[c][aw-1:0]) &&
                       (wr_ptr[c][aw] != rd_ptr[c][aw]);
        end
    end

    assign o_valid = &(~empty);
    assign o_full  = |full;
    assign o_ready = ~o_full;
    assign pop     = rd & o_valid;

    // A full column may still accept a write when the same edge pops it.
    always_comb begin
        we = '0;
        for (int c = 0; c < int'(col); c++) begin
            we[c] = wr[c] & (~full[c] | pop);
        end
    end

    // Pointer update: writes per column, pops on all columns together.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < int'(col); c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
            end
        end else begin
            for (int c = 0; c < int'(col); c++) begin
                if (we[c]) wr_ptr[c] <= wr_ptr[c] + ptr_w'(1);
                if (pop)   rd_ptr[c] <= rd_ptr[c] + ptr_w'(1);
            end
        end
    end

    // Storage is never cleared; only the pointers define valid content.
    always_ff @(posedge clk) begin
        for (int c = 0; c < int'(col); c++) begin
            if (we[c] && !reset) begin
                mem[c][wr_ptr[c][aw-1:0]] <= in[psum_bw*c +: psum_bw];
            end
        end
    end

    // Sticky overflow: a write to a full column that is not popped this edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_ovf <= 1'b0;
        end else if (|(wr & full & ~{col{pop}})) begin
            o_ovf <= 1'b1;
        end
    end

    // Show-ahead head of every column, optionally clamped at zero.
    always_comb begin
        out = '0;
        for (int c = 0; c < int'(col); c++) begin
`ifdef OFIFO_RELU_EN
            out[psum_bw*c +: psum_bw] = mem[c][rd_ptr[c][aw-1:0]][psum_bw-1] ?
                                        '0 : mem[c][rd_ptr[c][aw-1:0]];
`else
            out[psum_bw*c +: psum_bw] = mem[c][rd_ptr[c][aw-1:0]];
`endif
        end
    end

endmodule
